ins_fetcher: RTL and testbench
==============================

// Module: ins_fetcher
// PURPOSE
//  Front-end fetch stage directly upstream of the decoder. Holds the PC, requests 32-bit
//  words from the instruction cache, presents one instruction at a time to the decoder and
//  advances to the decoder's next_PC when it is accepted. Redirects on ROB flush and discards
//  any cache response still in flight for the squashed path.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
// PORTS
//  clk_in        in   1   system clock; all state updates on rising edge
//  rst_in        in   1   synchronous, active-high reset
//  rdy_in        in   1   global ready; low freezes all state
//  icache_req    out  1   fetch request, held high until icache_valid
//  icache_addr   out  32  fetch address, stable while icache_req high
//  icache_valid  in   1   one-cycle response pulse
//  icache_inst   in   32  instruction word, valid with icache_valid
//  inst_input    out  1   instruction presented to decoder is valid
//  inst          out  32  instruction word to decoder
//  inst_addr     out  32  PC of presented instruction
//  is_stall      in   1   decoder cannot accept presented instruction this cycle
//  next_PC       in   32  decoder-computed successor PC of presented instruction
//  rob_clear     in   1   ROB flush / mispredict redirect
//  rob_new_pc    in   32  redirect target, valid with rob_clear
//  fetch_cnt     out  32  count of instructions accepted by the decoder
// BEHAVIOUR
//  - Reset (rst_in=1 at edge): pc=RESET_PC, state=IDLE, discard=0, icache_req=0,
//    icache_addr=0, inst_input=0, inst=0, inst_addr=0, fetch_cnt=0. Overrides rdy_in.
//  - rdy_in=0: no register changes; rob_clear and icache_valid ignored (cache also frozen).
//  - All outputs registered. Accept = inst_input & !is_stall (sampled at edge).
//  - States: IDLE, WAIT, HOLD.
//    IDLE: icache_req<=1, icache_addr<=pc -> WAIT.
//    WAIT: icache_req high. On icache_valid & !discard: inst<=icache_inst, inst_addr<=pc,
//      inst_input<=1, icache_req<=0 -> HOLD. On icache_valid & discard: discard<=0,
//      icache_req<=0 -> IDLE.
//    HOLD: inst/inst_addr/inst_input stable. On accept: pc<=next_PC, fetch_cnt+=1,
//      inst_input<=0, icache_req<=1, icache_addr<=next_PC -> WAIT (no IDLE bubble).
//      Otherwise remain.
//  - Minimum turnaround: accept to next inst_input = icache latency + 1 cycle.
//  - rob_clear (highest priority after reset/rdy): pc<=rob_new_pc, inst_input<=0; accept,
//    fetch_cnt and any icache_valid this cycle are ignored.
//    In IDLE/HOLD -> IDLE, icache_req<=0. In WAIT with icache_valid same cycle -> IDLE,
//    icache_req<=0, discard<=0. In WAIT without icache_valid -> stay WAIT, discard<=1,
//    icache_req and icache_addr unchanged (no cancel on cache side).
//  - Repeated rob_clear while discarding: pc takes latest rob_new_pc, discard stays 1.
//  - PC arithmetic is 32-bit modulo; fetcher never adds 4 itself (next_PC owns sequencing).
//  - fetch_cnt wraps 32'hFFFF_FFFF -> 0.
//  - icache_valid outside WAIT is ignored. inst_input never high in IDLE or WAIT.
// TESTING
//  1. Reset, RESET_PC=0, cache latency 2 -> icache_req=1 addr 0x0 cycle after reset release;
//     inst_input=1 inst_addr=0x0 after response; is_stall=0, next_PC=0x4 -> icache_addr=0x4.
//  2. Hold: is_stall=1 for 5 cycles while presenting 0x00500093@0x8 -> inst, inst_addr,
//     inst_input constant, no icache_req; release -> fetch_cnt +1 exactly once.
//  3. Jump: next_PC=0x1000 on accept at 0x10 -> icache_addr=0x1000, inst_addr=0x1000 next.
//  4. rob_clear rob_new_pc=0x200 in WAIT (fetching 0x20), response 3 cycles later -> that
//     word never presented (inst_input stays 0); new req addr=0x200, inst_addr=0x200.
//  5. rob_clear same cycle as accept in HOLD and same cycle as icache_valid in WAIT ->
//     fetch_cnt unchanged, response dropped, next req addr=rob_new_pc.
//  6. rdy_in=0 for 4 cycles mid-WAIT and mid-HOLD -> all outputs frozen; rst_in=1 in HOLD
//     -> all outputs to reset values next edge, pc=RESET_PC.

Source files
------------

// File: rtl/ins_fetcher.sv
// Instruction fetch stage: holds the PC, requests words from the icache and presents
// one instruction at a time to the decoder; redirects on ROB flush.
module ins_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_inst,
    output logic        inst_input,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    input  logic        is_stall,
    input  logic [31:0] next_PC,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_pc, w_pc_nx;
    logic        r_discard, w_discard_nx;
    logic        r_req, w_req_nx;
    logic [31:0] r_addr, w_addr_nx;
    logic        r_inst_input, w_inst_input_nx;
    logic [31:0] r_inst, w_inst_nx;
    logic [31:0] r_inst_addr, w_inst_addr_nx;
    logic [31:0] r_cnt, w_cnt_nx;
    logic        w_accept;

    assign w_accept = r_inst_input & ~is_stall;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_discard    <= 1'b0;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_inst_input <= 1'b0;
            r_inst       <= '0;
            r_inst_addr  <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_discard    <= w_discard_nx;
            r_req        <= w_req_nx;
            r_addr       <= w_addr_nx;
            r_inst_input <= w_inst_input_nx;
            r_inst       <= w_inst_nx;
            r_inst_addr  <= w_inst_addr_nx;
            r_cnt        <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_pc_nx         = r_pc;
        w_discard_nx    = r_discard;
        w_req_nx        = r_req;
        w_addr_nx       = r_addr;
        w_inst_input_nx = r_inst_input;
        w_inst_nx       = r_inst;
        w_inst_addr_nx  = r_inst_addr;
        w_cnt_nx        = r_cnt;
        if (rdy_in) begin
            if (rob_clear) begin
                w_pc_nx         = rob_new_pc;
                w_inst_input_nx = 1'b0;
                // A request in flight cannot be cancelled; mark its response for dropping.
                if (r_state == S_WAIT && !icache_valid) begin
                    w_discard_nx = 1'b1;
                end else begin
                    w_state_nx   = S_IDLE;
                    w_req_nx     = 1'b0;
                    w_discard_nx = 1'b0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_req_nx   = 1'b1;
                        w_addr_nx  = r_pc;
                        w_state_nx = S_WAIT;
                    end
                    S_WAIT: begin
                        if (icache_valid) begin
                            w_req_nx = 1'b0;
                            if (r_discard) begin
                                w_discard_nx = 1'b0;
                                w_state_nx   = S_IDLE;
                            end else begin
                                w_inst_nx       = icache_inst;
                                w_inst_addr_nx  = r_pc;
                                w_inst_input_nx = 1'b1;
                                w_state_nx      = S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (w_accept) begin
                            w_pc_nx         = next_PC;
                            w_cnt_nx        = r_cnt + 32'd1;
                            w_inst_input_nx = 1'b0;
                            w_req_nx        = 1'b1;
                            w_addr_nx       = next_PC;
                            w_state_nx      = S_WAIT;
                        end
                    end
                    default: w_state_nx = S_IDLE;
                endcase
            end
        end
    end

    assign icache_req  = r_req;
    assign icache_addr = r_addr;
    assign inst_input  = r_inst_input;
    assign inst        = r_inst;
    assign inst_addr   = r_inst_addr;
    assign fetch_cnt   = r_cnt;

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher: the icache is driven by hand from the stimulus sequence.
module tb_ins_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic        inst_input;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        is_stall;
    logic [31:0] next_PC;
    logic        rob_clear;
    logic [31:0] rob_new_pc;
    logic [31:0] fetch_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_cnt;

    ins_fetcher #(.RESET_PC(32'h0000_0000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_valid(icache_valid), .icache_inst(icache_inst),
        .inst_input(inst_input), .inst(inst), .inst_addr(inst_addr),
        .is_stall(is_stall), .next_PC(next_PC),
        .rob_clear(rob_clear), .rob_new_pc(rob_new_pc),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Request already issued for addr: one idle cycle, then the response pulse.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
        chk("fetch_req", {31'd0, icache_req}, 32'd1);
        chk("fetch_addr", icache_addr, addr);
        tick();
        icache_valid = 1'b1;
        icache_inst  = word;
        tick();
        icache_valid = 1'b0;
        chk("pres_valid", {31'd0, inst_input}, 32'd1);
        chk("pres_inst", inst, word);
        chk("pres_addr", inst_addr, addr);
        chk("pres_req", {31'd0, icache_req}, 32'd0);
    endtask

    task automatic accept(input logic [31:0] npc);
        is_stall = 1'b0;
        next_PC  = npc;
        tick();
        is_stall = 1'b1;
        exp_cnt  = exp_cnt + 32'd1;
        chk("acc_valid", {31'd0, inst_input}, 32'd0);
        chk("acc_req", {31'd0, icache_req}, 32'd1);
        chk("acc_addr", icache_addr, npc);
        chk("acc_cnt", fetch_cnt, exp_cnt);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; icache_valid = 1'b0; icache_inst = '0;
        is_stall = 1'b1; next_PC = '0; rob_clear = 1'b0; rob_new_pc = '0;
        exp_cnt = '0;
        tick();
        chk("rst_req", {31'd0, icache_req}, 32'd0);
        chk("rst_addr", icache_addr, 32'h0);
        chk("rst_valid", {31'd0, inst_input}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_iaddr", inst_addr, 32'h0);
        chk("rst_cnt", fetch_cnt, 32'h0);

        // Basic fetch and sequential accept
        rst_in = 1'b0;
        tick();
        fetch(32'h0, 32'h0000_0013);
        accept(32'h4);
        fetch(32'h4, 32'h0010_0093);
        accept(32'h8);

        // Decoder stall: presentation held, stray response outside WAIT ignored
        fetch(32'h8, 32'h0050_0093);
        for (int i = 0; i < 5; i++) begin
            icache_valid = (i == 2);
            icache_inst  = 32'hBAD0_BAD0;
            tick();
            chk("hold_valid", {31'd0, inst_input}, 32'd1);
            chk("hold_inst", inst, 32'h0050_0093);
            chk("hold_iaddr", inst_addr, 32'h8);
            chk("hold_req", {31'd0, icache_req}, 32'd0);
            chk("hold_cnt", fetch_cnt, exp_cnt);
        end
        icache_valid = 1'b0;
        accept(32'h10);
        tick();
        chk("once_cnt", fetch_cnt, exp_cnt);

        // Jump via next_PC
        fetch(32'h10, 32'h7F00_006F);
        accept(32'h1000);
        fetch(32'h1000, 32'h0000_0113);
        accept(32'h20);

        // Flush mid-WAIT: in-flight response for 0x20 is dropped
        rob_clear = 1'b1; rob_new_pc = 32'h200;
        tick();
        rob_clear = 1'b0;
        chk("fl_req", {31'd0, icache_req}, 32'd1);
        chk("fl_addr", icache_addr, 32'h20);
        chk("fl_valid", {31'd0, inst_input}, 32'd0);
        tick();
        tick();
        icache_valid = 1'b1; icache_inst = 32'hDEAD_BEEF;
        tick();
        icache_valid = 1'b0;
        chk("drop_valid", {31'd0, inst_input}, 32'd0);
        chk("drop_req", {31'd0, icache_req}, 32'd0);
        tick();
        chk("drop_valid2", {31'd0, inst_input}, 32'd0);
        fetch(32'h200, 32'h0020_0193);

        // Flush coincident with accept in HOLD
        is_stall = 1'b0; next_PC = 32'h300; rob_clear = 1'b1; rob_new_pc = 32'h400;
        tick();
        is_stall = 1'b1; rob_clear = 1'b0;
        chk("fa_valid", {31'd0, inst_input}, 32'd0);
        chk("fa_req", {31'd0, icache_req}, 32'd0);
        chk("fa_cnt", fetch_cnt, exp_cnt);
        tick();
        // Flush coincident with response in WAIT
        icache_valid = 1'b1; icache_inst = 32'hCAFE_F00D;
        rob_clear = 1'b1; rob_new_pc = 32'h500;
        chk("fa_addr", icache_addr, 32'h400);
        tick();
        icache_valid = 1'b0; rob_clear = 1'b0;
        chk("fv_valid", {31'd0, inst_input}, 32'd0);
        chk("fv_req", {31'd0, icache_req}, 32'd0);
        tick();
        fetch(32'h500, 32'h0030_0213);
        accept(32'h600);

        // Freeze mid-WAIT; flush and response are ignored while not ready
        rdy_in = 1'b0; icache_valid = 1'b1; icache_inst = 32'h1111_1111;
        rob_clear = 1'b1; rob_new_pc = 32'h900;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fzw_req", {31'd0, icache_req}, 32'd1);
            chk("fzw_addr", icache_addr, 32'h600);
            chk("fzw_valid", {31'd0, inst_input}, 32'd0);
            chk("fzw_cnt", fetch_cnt, exp_cnt);
        end
        rdy_in = 1'b1; icache_valid = 1'b0; rob_clear = 1'b0;
        fetch(32'h600, 32'h0040_0293);

        // Freeze mid-HOLD with decoder willing to accept
        rdy_in = 1'b0; is_stall = 1'b0; next_PC = 32'h700;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fzh_valid", {31'd0, inst_input}, 32'd1);
            chk("fzh_inst", inst, 32'h0040_0293);
            chk("fzh_iaddr", inst_addr, 32'h600);
            chk("fzh_req", {31'd0, icache_req}, 32'd0);
            chk("fzh_cnt", fetch_cnt, exp_cnt);
        end
        rdy_in = 1'b1; is_stall = 1'b1;

        // Reset from HOLD
        rst_in = 1'b1;
        tick();
        chk("rh_req", {31'd0, icache_req}, 32'd0);
        chk("rh_addr", icache_addr, 32'h0);
        chk("rh_valid", {31'd0, inst_input}, 32'd0);
        chk("rh_inst", inst, 32'h0);
        chk("rh_iaddr", inst_addr, 32'h0);
        chk("rh_cnt", fetch_cnt, 32'h0);
        rst_in = 1'b0;
        tick();
        chk("rh_pc_req", {31'd0, icache_req}, 32'd1);
        chk("rh_pc_addr", icache_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
